enc192_iter: RTL and testbench
==============================

// Module: enc192_iter
// PURPOSE
//  Iterative AES-192 encryptor: one round per clock, round keys expanded on the fly.
//  Encrypt-side counterpart of the unrolled AES-192 decryptor; ciphertext from this
//  block must decrypt back to the original plaintext under the same 192-bit key.
//  Built from the forward primitives: subByte, shift_rows, mix_columns,
//  add_round_key, key_expansion_192.
//  Valid/ready on both sides; one block in flight at a time.
// PARAMETERS
//  CLEAR_ON_POP  1  1: out returns to 128'h0 after the output handshake; 0: out holds the last ciphertext
// PORTS
//  clk        in   1    rising-edge clock (single clock domain)
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    plaintext and key presented
//  in_ready   out  1    block idle, can accept
//  in         in   128  plaintext, byte 0 = [127:120]
//  key        in   192  cipher key, word 0 = [191:160]
//  out_valid  out  1    ciphertext available
//  out_ready  in   1    consumer accepts ciphertext
//  out        out  128  ciphertext
// BEHAVIOUR
//  States: IDLE, RUN, DONE. Reset values: state=IDLE, round counter=0, state reg=0, out=0, out_valid=0.
//  While rst_n is low, in_ready=1 (IDLE).
//  in_ready = (state==IDLE); combinational from state only.
//  IDLE: on in_valid&&in_ready (accept cycle, edge T):
//    - state reg <= in ^ RK0; key inputs captured; rnd <= 1; -> RUN.
//  RUN, round r=1..11 (edges T+1..T+11): s <= ARK(MixCol(ShiftRows(SubBytes(s))), RKr).
//  Round 12 (edge T+12): s <= ARK(ShiftRows(SubBytes(s)), RK12); out <= result; out_valid <= 1; -> DONE.
//  Latency: out_valid is high in the cycle after edge T+12, i.e. 12 clocks after the accept edge.
//  Round keys:
//    - RKr = W[4r..4r+3] of the FIPS-197 schedule, Nk=6, Nr=12, 52 words.
//    - Expansion steps use rcon 01,02,04,08,10,20,40,80 (<<24), in that order, max one step per clock.
//    - Word mapping: RK0=key[191:64]; RK1={key[63:0],E0[191:128]}; RK2=E0[127:0]; RK3=E1[191:64];
//      then the same 3-round / 2-expansion pattern repeats (Ej = j-th key_expansion_192 output).
//    - Key storage is at most 320 flops (current 192-bit block + 128-bit carry); no full schedule precompute.
//  DONE:
//    - out and out_valid hold stable until out_ready=1.
//    - On handshake: out_valid <= 0; out <= 0 if CLEAR_ON_POP; -> IDLE.
//    - in_ready therefore rises the cycle after the pop; no same-cycle pop-and-accept.
//  in_valid while RUN/DONE: ignored; in and key are don't-care after the accept edge.
//  out_ready while not DONE: ignored.
//  Async reset mid-RUN or mid-DONE:
//    - Immediately: out_valid=0, out=0, state=IDLE.
//    - The partial block is discarded; no spurious out_valid after reset release.
//  All XOR/byte ops are pure GF(2^8); no width extension, no wrap on the round counter (stops at 12).
// TESTING
//  1. FIPS-197 C.2: key 000102030405060708090a0b0c0d0e0f1011121314151617,
//     pt 00112233445566778899aabbccddeeff -> out dda97ca4864cdfe06eaf70a0ec0d7191, out_valid exactly 12 clks after accept.
//  2. SP800-38A ECB-AES192: key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
//     pt 6bc1bee22e409f96e93d7e117393172a -> out bd334f1d6e45f25ff712a214571fa5cc.
//  3. All-zero key, all-zero pt -> out aae06992acbf52a3e8f4a96ec9300bd7.
//  4. Backpressure: out_ready=0 for 20 clks after out_valid -> out stable, in_ready=0 throughout;
//     in_valid pulses with new pt/key are ignored; pop, then out=0 (CLEAR_ON_POP=1) and in_ready=1 next clk.
//  5. Drive in/key to random values every cycle after accept -> result still equals the vector 1 ciphertext.
//  6. Assert rst_n=0 at round 6 -> out_valid=0, out=0 asynchronously.
//     Release, send vector 2 -> correct ciphertext, with no extra out_valid pulse.
//  Round-trip: feed each ciphertext to the AES-192 decryptor with the same key -> original pt.

Source files
------------

// File: rtl/enc192_iter.sv
// enc192_iter: iterative AES-192 encryptor, one round per clock, round keys expanded on the fly
module enc192_iter #(
  parameter bit CLEAR_ON_POP = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in,
  input  logic [191:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t st;
  logic [127:0] s;
  logic [191:0] kb;
  logic [3:0] rnd;
  logic [2:0] ri;
  logic [191:0] e;
  logic [3:0] m;
  logic [127:0] rk, sr, nx;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ t : p;
      t = xt(t);
    end
    return p;
  endfunction

  function automatic logic [7:0] sub_byte(input logic [7:0] x);
    logic [7:0] p, t;
    p = 8'h01;
    t = x;
    for (int i = 1; i < 8; i++) begin
      t = gm(t, t);
      p = gm(p, t);
    end
    return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sub_byte(x[127-8*i -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = x[127-8*(4*(((i/4)+(i%4))%4)+(i%4)) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] x);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = x[127-32*c -: 8];
      a1 = x[119-32*c -: 8];
      a2 = x[111-32*c -: 8];
      a3 = x[103-32*c -: 8];
      r[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      r[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return r;
  endfunction

  function automatic logic [191:0] key_expansion_192(input logic [191:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3, n4, n5;
    t  = {sub_byte(k[23:16]), sub_byte(k[15:8]), sub_byte(k[7:0]), sub_byte(k[31:24])} ^ {rc, 24'h0};
    n0 = k[191:160] ^ t;
    n1 = k[159:128] ^ n0;
    n2 = k[127:96] ^ n1;
    n3 = k[95:64] ^ n2;
    n4 = k[63:32] ^ n3;
    n5 = k[31:0] ^ n4;
    return {n0, n1, n2, n3, n4, n5};
  endfunction

  assign in_ready = (st == IDLE);

  // next 192-bit key block and the round key for the current round (rnd mod 3 picks the word window)
  always_comb begin
    e  = key_expansion_192(kb, 8'h01 << ri);
    m  = rnd % 4'd3;
    rk = m == 4'd1 ? {kb[63:0], e[191:128]} : m == 4'd2 ? kb[127:0] : e[191:64];
    sr = shift_rows(sub_bytes(s));
    nx = (rnd == 4'd12 ? sr : mix_columns(sr)) ^ rk;
  end

  // control FSM, round datapath, key window and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      s         <= '0;
      kb        <= '0;
      rnd       <= '0;
      ri        <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          s   <= in ^ key[191:64];
          kb  <= key;
          rnd <= 4'd1;
          ri  <= 3'd0;
          st  <= RUN;
        end
        RUN: begin
          s <= nx;
          if (m != 4'd2) begin
            kb <= e;
            ri <= ri + 3'd1;
          end
          if (rnd == 4'd12) begin
            out       <= nx;
            out_valid <= 1'b1;
            st        <= DONE;
          end else rnd <= rnd + 4'd1;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          out       <= CLEAR_ON_POP ? 128'h0 : out;
          st        <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_enc192_iter.sv
// tb_enc192_iter: directed-vector bench for enc192_iter
module tb_enc192_iter;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [127:0] pt_in = '0;
  logic [191:0] key = '0;
  logic in_ready, out_valid;
  logic [127:0] out;
  int n_chk = 0, n_fail = 0, lat;

  localparam logic [191:0] K1 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [191:0] K2 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [127:0] P2 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C2 = 128'hbd334f1d6e45f25ff712a214571fa5cc;
  localparam logic [127:0] C3 = 128'haae06992acbf52a3e8f4a96ec9300bd7;

  always #5 clk = ~clk;

  enc192_iter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in(pt_in), .key(key), .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [127:0] pt, input logic [191:0] k, input bit scr, output int l);
    int w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("in_ready_before_send", in_ready, 1);
    pt_in = pt;
    key = k;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    l = 0;
    while (!out_valid && l < 40) begin
      if (scr) begin
        pt_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        key = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      end
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic pop();
    check("busy_before_pop", in_ready, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("pop_out_valid", out_valid, 0);
    check("pop_out_cleared", out, 0);
    check("pop_in_ready", in_ready, 1);
  endtask

  initial begin
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(P1, K1, 1'b0, lat);
    check("v1_latency", lat, 12);
    check("v1_out", out, C1);
    pop();
    send(P2, K2, 1'b0, lat);
    check("v2_latency", lat, 12);
    check("v2_out", out, C2);
    pop();
    send(128'h0, 192'h0, 1'b0, lat);
    check("v3_latency", lat, 12);
    check("v3_out", out, C3);
    pop();
    send(P1, K1, 1'b0, lat);
    check("bp_latency", lat, 12);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      pt_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      key = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk); #1;
      check("bp_out_stable", out, C1);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    pop();
    send(P1, K1, 1'b1, lat);
    check("scramble_latency", lat, 12);
    check("scramble_out", out, C1);
    pop();
    send(P2, K2, 1'b0, lat);
    check("done_rst_pre", out, C2);
    #2 rst_n = 1'b0;
    #1;
    check("done_rst_out_valid", out_valid, 0);
    check("done_rst_out", out, 0);
    check("done_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pt_in = P1;
    key = K1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("run_accepted", in_ready, 0);
    repeat (6) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("run_rst_out_valid", out_valid, 0);
    check("run_rst_out", out, 0);
    check("run_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      check("no_spurious_valid", out_valid, 0);
    end
    send(P2, K2, 1'b0, lat);
    check("post_rst_latency", lat, 12);
    check("post_rst_out", out, C2);
    pop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
